// File: rtl/rr_arbiter_lock.sv
`default_nettype none
// ============================================================================
// Module  : rr_arbiter_lock
// Brief   : NUM_REQ-way round-robin arbiter with registered one-hot grant,
//           per-owner burst lock and bounded hold time with timeout pulse.
// Revision: 1.0
// ============================================================================
module rr_arbiter_lock #(
   parameter int NUM_REQ  = 4,
   parameter int IDX_W    = $clog2(NUM_REQ),
   parameter int MAX_HOLD = 16,
   parameter int HOLD_W   = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req,
   input  logic [NUM_REQ-1:0] lock,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IDX_W-1:0]   gnt_idx,
   output logic               gnt_valid,
   output logic               timeout
);

   localparam logic [HOLD_W-1:0] HOLD_LAST =
      (MAX_HOLD == 0) ? '0 : HOLD_W'(MAX_HOLD - 1);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t             state;
   logic [IDX_W-1:0]   ptr;
   logic [HOLD_W-1:0]  hold_cnt;

   logic               locked;
   logic               keep;
   logic               forced;
   logic [NUM_REQ-1:0] cand;
   logic               win_found;
   logic [IDX_W-1:0]   win_idx;
   logic [IDX_W-1:0]   ptr_nxt;

   assign locked = (state == GRANT) && req[gnt_idx] && lock[gnt_idx];
   assign keep   = locked && ((MAX_HOLD == 0) || (hold_cnt < HOLD_LAST));
   assign forced = locked && !keep;
   // A timed-out owner is excluded for one arbitration so it cannot re-win itself.
   assign cand   = forced ? (req & ~gnt) : req;

   always_comb begin
      int j;
      win_found = 1'b0;
      win_idx   = '0;
      j         = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         j = int'(ptr) + k;
         if (j >= NUM_REQ) j = j - NUM_REQ;
         if (!win_found && cand[j]) begin
            win_found = 1'b1;
            win_idx   = IDX_W'(j);
         end
      end
   end

   assign ptr_nxt   = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
   assign gnt_valid = |gnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         gnt      <= '0;
         gnt_idx  <= '0;
         timeout  <= 1'b0;
         ptr      <= '0;
         hold_cnt <= '0;
      end else begin
         timeout <= 1'b0;
         case (state)
            IDLE: begin
               if (win_found) begin
                  state    <= GRANT;
                  gnt      <= NUM_REQ'(1) << win_idx;
                  gnt_idx  <= win_idx;
                  ptr      <= ptr_nxt;
                  hold_cnt <= '0;
               end
            end
            GRANT: begin
               if (keep) begin
                  if (hold_cnt != '1) hold_cnt <= hold_cnt + 1'b1;
               end else begin
                  timeout <= forced;
                  if (win_found) begin
                     gnt      <= NUM_REQ'(1) << win_idx;
                     gnt_idx  <= win_idx;
                     ptr      <= ptr_nxt;
                     hold_cnt <= '0;
                  end else begin
                     state   <= IDLE;
                     gnt     <= '0;
                     gnt_idx <= '0;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter_lock.sv
`default_nettype none
// ============================================================================
// Module  : tb_rr_arbiter_lock
// Brief   : Self-checking bench: vector table, corner sequences and random
//           traffic against a behavioural arbiter model (MAX_HOLD 16 and 4).
// Revision: 1.0
// ============================================================================
module tb_rr_arbiter_lock;

   localparam int N = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic [N-1:0] req;
   logic [N-1:0] lock;
   logic [N-1:0] gnt,  gnt4;
   logic [1:0]   idx,  idx4;
   logic         vld,  vld4;
   logic         to,   to4;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   rr_arbiter_lock #(.NUM_REQ(N), .MAX_HOLD(16), .HOLD_W(5)) dut (
      .clk(clk), .rst(rst), .req(req), .lock(lock),
      .gnt(gnt), .gnt_idx(idx), .gnt_valid(vld), .timeout(to)
   );

   rr_arbiter_lock #(.NUM_REQ(N), .MAX_HOLD(4), .HOLD_W(5)) dut4 (
      .clk(clk), .rst(rst), .req(req), .lock(lock),
      .gnt(gnt4), .gnt_idx(idx4), .gnt_valid(vld4), .timeout(to4)
   );

   typedef struct {
      bit valid;
      int owner;
      int ptr;
      int hold;
      bit to;
   } mstate_t;

   mstate_t m16, m4;

   // Reference: ownership described as (valid, owner index), priority by rotation.
   function automatic mstate_t mnext(mstate_t s, logic r, logic [N-1:0] rq,
                                     logic [N-1:0] lk, int max_hold);
      mstate_t      n;
      logic [N-1:0] c;
      bit           arb;
      int           w;
      n     = s;
      n.to  = 1'b0;
      if (r) begin
         n = '{valid: 1'b0, owner: 0, ptr: 0, hold: 0, to: 1'b0};
         return n;
      end
      c   = rq;
      arb = 1'b1;
      if (s.valid && rq[s.owner] && lk[s.owner]) begin
         if (max_hold == 0 || s.hold < max_hold - 1) begin
            if (s.hold < 31) n.hold = s.hold + 1;
            arb = 1'b0;
         end else begin
            n.to       = 1'b1;
            c[s.owner] = 1'b0;
         end
      end
      if (arb) begin
         w = -1;
         for (int k = N - 1; k >= 0; k--)
            if (c[(s.ptr + k) % N]) w = (s.ptr + k) % N;
         if (w >= 0) begin
            n.valid = 1'b1;
            n.owner = w;
            n.hold  = 0;
            n.ptr   = (w + 1) % N;
         end else begin
            n.valid = 1'b0;
            n.owner = 0;
         end
      end
      return n;
   endfunction

   function automatic logic [N-1:0] mgnt(mstate_t s);
      logic [N-1:0] g;
      g = '0;
      if (s.valid) g[s.owner] = 1'b1;
      return g;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cmp_model();
      chk("m16_gnt", 32'(gnt), 32'(mgnt(m16)));
      chk("m16_idx", 32'(idx), 32'(m16.valid ? m16.owner : 0));
      chk("m16_vld", 32'(vld), 32'(m16.valid));
      chk("m16_to",  32'(to),  32'(m16.to));
      chk("m16_ptr", 32'(dut.ptr), 32'(m16.ptr));
      chk("m4_gnt",  32'(gnt4), 32'(mgnt(m4)));
      chk("m4_idx",  32'(idx4), 32'(m4.valid ? m4.owner : 0));
      chk("m4_vld",  32'(vld4), 32'(m4.valid));
      chk("m4_to",   32'(to4),  32'(m4.to));
      chk("onehot",  32'($onehot0(gnt) && $onehot0(gnt4)), 32'd1);
   endtask

   task automatic step(input logic r, input logic [N-1:0] rq, input logic [N-1:0] lk);
      rst  = r;
      req  = rq;
      lock = lk;
      @(posedge clk);
      m16 = mnext(m16, r, rq, lk, 16);
      m4  = mnext(m4,  r, rq, lk, 4);
      #1;
      cmp_model();
   endtask

   typedef struct {
      logic         r;
      logic [N-1:0] rq;
      logic [N-1:0] lk;
      logic [N-1:0] exp_gnt;
      logic [1:0]   exp_ptr;
      logic         exp_to;
   } vec_t;

   vec_t vt[10];
   int   cnt;

   initial begin
      rst  = 1'b1;
      req  = '0;
      lock = '0;
      m16  = '{valid: 1'b0, owner: 0, ptr: 0, hold: 0, to: 1'b0};
      m4   = m16;

      vt[0] = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0};
      vt[1] = '{1'b0, 4'b1111, 4'b0000, 4'b0001, 2'd1, 1'b0};
      vt[2] = '{1'b0, 4'b1111, 4'b0000, 4'b0010, 2'd2, 1'b0};
      vt[3] = '{1'b0, 4'b1111, 4'b0000, 4'b0100, 2'd3, 1'b0};
      vt[4] = '{1'b0, 4'b1111, 4'b0000, 4'b1000, 2'd0, 1'b0};
      vt[5] = '{1'b0, 4'b1111, 4'b0000, 4'b0001, 2'd1, 1'b0};
      vt[6] = '{1'b0, 4'b0100, 4'b0000, 4'b0100, 2'd3, 1'b0};
      vt[7] = '{1'b0, 4'b0100, 4'b0000, 4'b0100, 2'd3, 1'b0};
      vt[8] = '{1'b0, 4'b0100, 4'b0000, 4'b0100, 2'd3, 1'b0};
      vt[9] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd3, 1'b0};

      foreach (vt[i]) begin
         step(vt[i].r, vt[i].rq, vt[i].lk);
         chk("tbl_gnt", 32'(gnt), 32'(vt[i].exp_gnt));
         chk("tbl_ptr", 32'(dut.ptr), 32'(vt[i].exp_ptr));
         chk("tbl_to",  32'(to), 32'(vt[i].exp_to));
         chk("tbl_vld", 32'(vld), 32'(vt[i].exp_gnt != 0));
      end

      // Owner 1 locked against requester 0: 16 cycles of hold then forced hand-over.
      cnt = 0;
      step(1'b0, 4'b0010, 4'b0010);
      if (gnt == 4'b0010) cnt++;
      for (int i = 0; i < 15; i++) begin
         step(1'b0, 4'b0011, 4'b0010);
         if (gnt == 4'b0010 && !to) cnt++;
      end
      chk("hold16_cycles", 32'(cnt), 32'd16);
      step(1'b0, 4'b0011, 4'b0010);
      chk("hold16_handover", 32'(gnt), 32'b0001);
      chk("hold16_timeout", 32'(to), 32'd1);
      step(1'b0, 4'b0011, 4'b0000);
      chk("hold16_to_pulse", 32'(to), 32'd0);
      chk("hold16_next", 32'(gnt), 32'b0010);

      // Lone locked owner with MAX_HOLD=4: bubble on forced release.
      step(1'b0, 4'b0000, 4'b0000);
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 4'b0100, 4'b0100);
         chk("hold4_gnt", 32'(gnt4), 32'b0100);
         chk("hold4_to0", 32'(to4), 32'd0);
      end
      step(1'b0, 4'b0100, 4'b0100);
      chk("hold4_bubble", 32'(gnt4), 32'b0000);
      chk("hold4_timeout", 32'(to4), 32'd1);
      step(1'b0, 4'b0100, 4'b0100);
      chk("hold4_regrant", 32'(gnt4), 32'b0100);
      chk("hold4_to_end", 32'(to4), 32'd0);

      // Locked owner 0 drops its request: immediate hand-over, no bubble.
      step(1'b0, 4'b0000, 4'b0000);
      step(1'b0, 4'b0001, 4'b0001);
      for (int i = 0; i < 4; i++) step(1'b0, 4'b1011, 4'b0001);
      chk("drop_held", 32'(gnt), 32'b0001);
      step(1'b0, 4'b1010, 4'b0001);
      chk("drop_gnt", 32'(gnt), 32'b0010);
      chk("drop_to", 32'(to), 32'd0);

      // Reset while owner 3 holds a lock.
      step(1'b0, 4'b0000, 4'b0000);
      step(1'b0, 4'b1000, 4'b1000);
      step(1'b0, 4'b1000, 4'b1000);
      chk("rst_owner3", 32'(gnt), 32'b1000);
      step(1'b1, 4'b1000, 4'b1000);
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_idx", 32'(idx), 32'd0);
      chk("rst_ptr", 32'(dut.ptr), 32'd0);
      step(1'b0, 4'b1001, 4'b0000);
      chk("rst_first", 32'(gnt), 32'b0001);

      for (int i = 0; i < 500; i++) begin
         logic [N-1:0] rq, lk;
         rq = req;
         if ($urandom_range(0, 3) == 0) rq = N'($urandom);
         lk = ($urandom_range(0, 3) != 0) ? 4'hF : N'($urandom);
         step($urandom_range(0, 49) == 0, rq, lk);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/rr_arbiter_lock.md
Name: rr_arbiter_lock

Overview:
- Parametrised round-robin arbiter for the multicore shared-resource path (shared bus / memory port), generalising the fixed 3-requester arbiter to NUM_REQ requesters.
- Adds a registered one-hot grant and a fairness pointer that advances only on an actual grant.
- Adds per-requester lock (burst hold) with a bounded maximum hold time, plus a timeout indication.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- IDX_W, $clog2(NUM_REQ), width of grant index (derived; do not override).
- MAX_HOLD, 16, max consecutive cycles one owner may hold a locked grant. 0 = unlimited, no timeout.
- HOLD_W, 5, width of hold counter. Must hold MAX_HOLD.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- req  input  NUM_REQ  per-requester request, level.
- lock  input  NUM_REQ  per-requester hold request; only meaningful while that requester owns the grant.
- gnt  output  NUM_REQ  registered one-hot grant (all zero = no owner).
- gnt_idx  output  IDX_W  index of current owner; 0 when gnt_valid=0.
- gnt_valid  output  1  OR of gnt.
- timeout  output  1  one-cycle pulse, same cycle the forced release takes effect in gnt.

Behaviour:
- Reset: gnt=0, gnt_idx=0, gnt_valid=0, timeout=0, pointer ptr=0, hold_cnt=0, state IDLE.
- Latency: req sampled at edge t produces gnt at edge t+1. No combinational path from req to gnt.
- Winner selection: winner = first index i with cand[i]=1, scanning ptr, ptr+1, ..., NUM_REQ-1, 0, ..., ptr-1. cand defaults to req.
- Pointer update: on every cycle a new owner w is loaded (different owner, or re-grant after release), ptr <= (w+1) mod NUM_REQ. The pointer wraps at NUM_REQ-1 → 0. It does not move while idle or while a grant is held.
- State IDLE (gnt=0):
  - If any req, load winner, hold_cnt<=0, go to GRANT.
  - Otherwise stay in IDLE.
- State GRANT (owner o):
  - Keep: if req[o]=1, lock[o]=1 and (MAX_HOLD=0 or hold_cnt<MAX_HOLD-1), then gnt is unchanged and hold_cnt++.
  - Forced release: if req[o]=1, lock[o]=1 and hold_cnt=MAX_HOLD-1, assert timeout for the next cycle and re-arbitrate with cand = req & ~onehot(o).
    - If cand is empty, gnt becomes 0 (IDLE) for at least one cycle before o may win again.
  - Normal release (req[o]=0 or lock[o]=0): re-arbitrate with cand=req, with no bubble. Because ptr has already moved past o, o re-wins only if it is the sole requester.
  - If no candidate, go to IDLE with gnt=0.
- A one-cycle grant with lock=0 is a single-beat transfer. Back-to-back requests from several requesters get one grant per cycle in rotating order.
- lock on a non-owner is ignored. req dropping on a locked owner releases immediately (next edge).
- hold_cnt resets to 0 on every new owner load. It saturates; it never wraps.
- rst asserted mid-grant returns to reset values at the next edge regardless of lock.
- Invariant (assertable): gnt is one-hot or zero at all times. gnt_idx matches gnt.

Test Plan:
- NUM_REQ=4, rst then req=4'b1111, lock=0 held → gnt sequence 0001, 0010, 0100, 1000, 0001. First grant appears 1 cycle after req; gnt_valid=1 throughout.
- req=4'b0100 only, lock=0 → gnt=0100 every cycle (sole-requester re-grant). ptr reads 3 after each grant.
- Owner 1 with lock=1, req=4'b0011, MAX_HOLD=16 → gnt=0010 for exactly 16 cycles. The next cycle has gnt=0001 and timeout=1 for 1 cycle.
- Owner 2 locked alone, MAX_HOLD=4 → gnt=0100 for 4 cycles, then gnt=0000 and timeout=1 for one cycle, then gnt=0100 again.
- Owner 0 locked, req[0] drops at cycle 5 while req=4'b1010 → gnt=0010 at cycle 6, with no idle bubble and timeout=0.
- rst pulsed while owner 3 is locked → next cycle gnt=0, gnt_idx=0, ptr=0. With req=4'b1001 afterwards, the first grant is 0001.
